// File: rtl/nios2_irq_controller_pkg.sv
// ============================================================================
// nios2_irq_controller_pkg
// Shared register map and width constants for the interrupt controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nios2_irq_controller_pkg;

  localparam int DATA_W   = 16;
  localparam int IRQ_ID_W = 4;
  localparam int MAX_IRQ  = 16;

  localparam logic [2:0] ADDR_RAW      = 3'd0;
  localparam logic [2:0] ADDR_PENDING  = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd4;
  localparam logic [2:0] ADDR_FORCE    = 3'd5;

endpackage

`default_nettype wire

// File: rtl/nios2_irq_controller_irq_sync_edge.sv
// ============================================================================
// irq_sync_edge
// Two-flop synchroniser per interrupt line plus rising-edge detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module irq_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync2,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign sync2 = r_sync2;
  assign rise  = r_sync2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/nios2_irq_controller.sv
// ============================================================================
// nios2_irq_controller
// Avalon-MM interrupt aggregator: latch, mask, prioritise and forward to Nios II.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nios2_irq_controller
  import nios2_irq_controller_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  input  logic [NUM_IRQ-1:0]  irq_in,
  output logic                irq_out,
  output logic [IRQ_ID_W-1:0] irq_id
);

  logic [NUM_IRQ-1:0] w_sync2;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_edge_sel;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_force;
  logic [NUM_IRQ-1:0] w_clear;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_pending_nxt;
  logic [NUM_IRQ-1:0] w_active;
  logic [DATA_W-1:0]  w_rd_mux;
  logic               w_wr_en;
  logic               w_unused_wdata;

  function automatic logic [IRQ_ID_W-1:0] prio_enc(input logic [NUM_IRQ-1:0] vec);
    logic [IRQ_ID_W-1:0] id;
    id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) id = IRQ_ID_W'(i);
    end
    return id;
  endfunction

  function automatic logic [DATA_W-1:0] zext(input logic [NUM_IRQ-1:0] vec);
    logic [DATA_W-1:0] res;
    res = '0;
    res[NUM_IRQ-1:0] = vec;
    return res;
  endfunction

  irq_sync_edge #(
    .WIDTH    (NUM_IRQ)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (irq_in),
    .sync2    (w_sync2),
    .rise     (w_rise)
  );

  assign w_wr_en        = chipselect && !write_n;
  assign w_wdata        = writedata[NUM_IRQ-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_force        = (w_wr_en && address == ADDR_FORCE)   ? w_wdata : '0;
  assign w_clear        = (w_wr_en && address == ADDR_PENDING) ? w_wdata : '0;
  assign w_set          = (r_edge_sel & w_rise) | (~r_edge_sel & w_sync2);

  // Force and set both outrank the W1C clear.
  assign w_pending_nxt  = w_force | w_set | (r_pending & ~w_clear);
  assign w_active       = r_pending & r_mask;

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_RAW:      w_rd_mux = zext(w_sync2);
      ADDR_PENDING:  w_rd_mux = zext(r_pending);
      ADDR_MASK:     w_rd_mux = zext(r_mask);
      ADDR_EDGE_SEL: w_rd_mux = zext(r_edge_sel);
      ADDR_ACTIVE:   w_rd_mux = {irq_out, {(DATA_W-1-IRQ_ID_W){1'b0}}, irq_id};
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_mask     <= '0;
      r_edge_sel <= '0;
      readdata   <= '0;
      irq_out    <= 1'b0;
      irq_id     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_wr_en && address == ADDR_MASK)     r_mask     <= w_wdata;
      if (w_wr_en && address == ADDR_EDGE_SEL) r_edge_sel <= w_wdata;
      readdata  <= w_rd_mux;
      irq_out   <= |w_active;
      irq_id    <= prio_enc(w_active);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nios2_irq_controller.sv
// Directed plus randomised bench for nios2_irq_controller with a rule-level reference model.
`default_nettype none

module tb_nios2_irq_controller;
  import nios2_irq_controller_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [N-1:0] irq_in;
  logic        irq_out;
  logic [3:0]  irq_id;

  int checks = 0;
  int errors = 0;

  // Reference state: input sample history (h1 newest) and architectural registers.
  logic [N-1:0] m_h1, m_h2, m_h3, m_pend, m_mask, m_edge;
  logic         m_irq;
  logic [3:0]   m_id;
  logic [15:0]  m_rd;

  always #5 clk = ~clk;

  nios2_irq_controller #(.NUM_IRQ(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out),
    .irq_id     (irq_id)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_rd"}, readdata, m_rd);
    chk({tag, "_irq"}, {15'd0, irq_out}, {15'd0, m_irq});
    chk({tag, "_id"}, {12'd0, irq_id}, {12'd0, m_id});
  endtask

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_h3 = '0;
    m_pend = '0; m_mask = '0; m_edge = '0;
    m_irq = 1'b0; m_id = '0; m_rd = '0;
  endtask

  // One clock: predict from pre-edge state, wait for the edge, then commit.
  task automatic tick();
    logic [N-1:0] set, frc, clr, np, act, nmask, nedge, wd;
    logic         wr, ni;
    logic [3:0]   nid;
    logic [15:0]  nrd;
    wr  = chipselect && !write_n;
    wd  = writedata[N-1:0];
    frc = (wr && address == ADDR_FORCE)   ? wd : '0;
    clr = (wr && address == ADDR_PENDING) ? wd : '0;
    for (int i = 0; i < N; i++) begin
      set[i] = m_edge[i] ? (m_h2[i] && !m_h3[i]) : m_h2[i];
      if (frc[i])      np[i] = 1'b1;
      else if (set[i]) np[i] = 1'b1;
      else if (clr[i]) np[i] = 1'b0;
      else             np[i] = m_pend[i];
    end
    act = m_pend & m_mask;
    ni  = (act != '0);
    nid = '0;
    for (int i = N - 1; i >= 0; i--) if (act[i]) nid = 4'(i);
    case (address)
      3'd0:    nrd = {8'd0, m_h2};
      3'd1:    nrd = {8'd0, m_pend};
      3'd2:    nrd = {8'd0, m_mask};
      3'd3:    nrd = {8'd0, m_edge};
      3'd4:    nrd = {m_irq, 11'd0, m_id};
      default: nrd = 16'd0;
    endcase
    nmask = (wr && address == ADDR_MASK)     ? wd : m_mask;
    nedge = (wr && address == ADDR_EDGE_SEL) ? wd : m_edge;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = irq_in;
      m_pend = np; m_mask = nmask; m_edge = nedge;
      m_irq = ni; m_id = nid; m_rd = nrd;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; irq_in = '0;
    model_reset();
    ticks(2);
    chk("rst_rd", readdata, 16'h0000);
    chk("rst_irq", {15'd0, irq_out}, 16'd0);
    chk("rst_id", {12'd0, irq_id}, 16'd0);
    reset_n = 1'b1;
    rd_reg(ADDR_MASK);
    chk("rst_mask", readdata, 16'h0000);
    rd_reg(ADDR_EDGE_SEL);
    chk("rst_edge", readdata, 16'h0000);

    // Edge pulse on source 0, then W1C.
    wr_reg(ADDR_MASK, 16'h0001);
    wr_reg(ADDR_EDGE_SEL, 16'h0001);
    irq_in = 8'h01; tick();
    irq_in = 8'h00; ticks(2);
    chk("edge_early", {15'd0, irq_out}, 16'd0);
    tick();
    chk("edge_irq", {15'd0, irq_out}, 16'd1);
    chk("edge_id", {12'd0, irq_id}, 16'd0);
    rd_reg(ADDR_ACTIVE);
    chk("edge_active", readdata, 16'h8000);
    wr_reg(ADDR_PENDING, 16'h0001);
    chk("w1c_same", {15'd0, irq_out}, 16'd1);
    tick();
    chk("w1c_next", {15'd0, irq_out}, 16'd0);
    chk_model("s2");

    // Level source cannot be cleared while held high.
    wr_reg(ADDR_EDGE_SEL, 16'h0000);
    wr_reg(ADDR_MASK, 16'h0004);
    irq_in = 8'h04; ticks(4);
    chk("lvl_irq", {15'd0, irq_out}, 16'd1);
    wr_reg(ADDR_PENDING, 16'h0004);
    rd_reg(ADDR_PENDING);
    chk("lvl_hold", readdata, 16'h0004);
    tick();
    chk("lvl_irq_hold", {15'd0, irq_out}, 16'd1);
    irq_in = 8'h00; ticks(3);
    wr_reg(ADDR_PENDING, 16'h0004);
    rd_reg(ADDR_PENDING);
    chk("lvl_clr", readdata, 16'h0000);
    ticks(2);
    chk("lvl_irq_off", {15'd0, irq_out}, 16'd0);
    chk_model("s3");

    // Forced sources and priority.
    wr_reg(ADDR_MASK, 16'h00FF);
    wr_reg(ADDR_FORCE, 16'h0028);
    tick();
    chk("frc_id3", {12'd0, irq_id}, 16'd3);
    rd_reg(ADDR_ACTIVE);
    chk("frc_active", readdata, 16'h8003);
    wr_reg(ADDR_PENDING, 16'h0008);
    tick();
    chk("frc_id5", {12'd0, irq_id}, 16'd5);
    wr_reg(ADDR_PENDING, 16'h0020);
    tick();
    chk("frc_irq_off", {15'd0, irq_out}, 16'd0);
    chk("frc_id0", {12'd0, irq_id}, 16'd0);
    rd_reg(ADDR_FORCE);
    chk("frc_reads0", readdata, 16'h0000);

    // Masked pending appears once unmasked.
    wr_reg(ADDR_MASK, 16'h0000);
    wr_reg(ADDR_EDGE_SEL, 16'h0080);
    irq_in = 8'h80; tick();
    irq_in = 8'h00; ticks(2);
    rd_reg(ADDR_PENDING);
    chk("msk_pend", readdata, 16'h0080);
    chk("msk_irq", {15'd0, irq_out}, 16'd0);
    wr_reg(ADDR_MASK, 16'h0080);
    ticks(2);
    chk("unmsk_irq", {15'd0, irq_out}, 16'd1);
    chk("unmsk_id", {12'd0, irq_id}, 16'd7);
    chk_model("s5");

    // Rise arriving at pending together with a W1C of the same bit.
    wr_reg(ADDR_PENDING, 16'h0080);
    wr_reg(ADDR_EDGE_SEL, 16'h0082);
    wr_reg(ADDR_MASK, 16'h0002);
    irq_in = 8'h02; ticks(2);
    wr_reg(ADDR_PENDING, 16'h0002);
    rd_reg(ADDR_PENDING);
    chk("race_pend", readdata, 16'h0002);
    irq_in = 8'h00;
    chk_model("s6");

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      irq_in     = 8'($urandom) & 8'($urandom);
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = 16'($urandom);
      tick();
      chk_model("rand");
    end

    // Asynchronous reset mid-cycle, then level re-pend from a held input.
    chipselect = 1'b0; write_n = 1'b1; address = ADDR_ACTIVE;
    wr_reg(ADDR_MASK, 16'h00FF);
    wr_reg(ADDR_FORCE, 16'h0010);
    ticks(2);
    irq_in = 8'h01;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rd", readdata, 16'h0000);
    chk("arst_irq", {15'd0, irq_out}, 16'd0);
    chk("arst_id", {12'd0, irq_id}, 16'd0);
    model_reset();
    ticks(2);
    reset_n = 1'b1;
    wr_reg(ADDR_MASK, 16'h0001);
    ticks(3);
    chk("repend_irq", {15'd0, irq_out}, 16'd1);
    chk_model("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
